// File: rtl/llr_rect_qam_demapper_if.sv
// llr_rect_qam_demapper_if: symbol-in / LLR-out stream bundle for the QAM demapper.
// Optional iscale field present when LLR_DEMAP_ISCALE_EN is defined.
interface llr_rect_qam_demapper_if #(
   parameter int pBMAX  = 12,
   parameter int pDAT_W = 9,
   parameter int pLLR_W = 4
);
   logic                      sym_val, sym_rdy, sym_sop;
   logic [4:0]                sym_qam;
   logic signed [pDAT_W-1:0]  re, im;
`ifdef LLR_DEMAP_ISCALE_EN
   logic [1:0]                scale;
`endif
   logic                      llr_val, llr_rdy, llr_sop, err;
   logic [4:0]                llr_qam;
   logic [pBMAX*pLLR_W-1:0]   llr;
   modport master (
      output sym_val, sym_sop, sym_qam, re, im, llr_rdy,
`ifdef LLR_DEMAP_ISCALE_EN
      output scale,
`endif
      input  sym_rdy, llr_val, llr_sop, llr_qam, err, llr
   );
   modport slave (
      input  sym_val, sym_sop, sym_qam, re, im, llr_rdy,
`ifdef LLR_DEMAP_ISCALE_EN
      input  scale,
`endif
      output sym_rdy, llr_val, llr_sop, llr_qam, err, llr
   );
endinterface

// File: rtl/llr_rect_qam_demapper.sv
// llr_rect_qam_demapper: pipelined max-log LLR demapper for Gray rectangular QAM, B=1..pBMAX per symbol.
// Define LLR_DEMAP_ISCALE_EN to add a per-symbol extra output shift (bus.scale).
module llr_rect_qam_demapper #(
   parameter int pBMAX      = 12,
   parameter int pDAT_W     = 9,
   parameter int pLLR_W     = 4,
   parameter int pSHIFT     = 4,
   parameter int pOUT_SHIFT = 4
) (
   input logic clk,
   input logic rst_n,
   llr_rect_qam_demapper_if.slave bus
);
   localparam int S = (pBMAX + 1) / 2 - 1;
   localparam int N = S + 2;
   localparam int W = pDAT_W + 1;
   localparam int D = 2 * (S + 1);
   localparam logic signed [W-1:0] MAXL = W'((1 << (pLLR_W - 1)) - 1);
   typedef logic [D-1:0][W-1:0] dvec_t;

   function automatic int m_i(input logic [4:0] q);
      return (int'(q) + 1) / 2;
   endfunction
   function automatic int m_q(input logic [4:0] q);
      return int'(q) / 2;
   endfunction
   // T_k - |d|; T_k beyond the internal width wraps to zero like the rest of the arithmetic
   function automatic logic [W-1:0] lvl(input logic [W-1:0] p, input int m, input int k);
      int a;
      a = m - k + pSHIFT;
      return ((a < 0 || a >= W) ? W'(0) : W'(1) << a) - (p[W-1] ? -p : p);
   endfunction

   logic             vld [N-1];
   logic             sop [N-1];
   logic [4:0]       qam [N-1];
   logic [1:0]       scl [N-1];
   dvec_t            d   [N-1];
   logic [N-1:0]     vv, adv;
   logic             ov, osop, oe, lg;
   logic [4:0]       oq;
   logic [pBMAX*pLLR_W-1:0] ol, nl;
   logic signed [W-1:0] sd;

   always_comb begin
      for (int i = 0; i < N - 1; i++) vv[i] = vld[i];
      vv[N-1] = ov;
   end

   // a stage may load whenever any stage at or after it is empty, or the sink pops
   for (genvar g = 0; g < N; g++) begin : ad
      assign adv[g] = ~(&vv[N-1:g]) | bus.llr_rdy;
   end

   for (genvar g = 0; g < N - 1; g++) begin : stg
      dvec_t      nd;
      logic       pv, ps;
      logic [4:0] pq;
      logic [1:0] pc;
      if (g == 0) begin : in0
         always_comb begin
            pv = bus.sym_val;
            ps = bus.sym_sop;
            pq = bus.sym_qam;
`ifdef LLR_DEMAP_ISCALE_EN
            pc = bus.scale;
`else
            pc = 2'd0;
`endif
            nd = '0;
            nd[0] = W'(bus.re);
            nd[1] = W'(bus.im);
         end
      end else begin : lv
         always_comb begin
            pv = vld[g-1];
            ps = sop[g-1];
            pq = qam[g-1];
            pc = scl[g-1];
            nd = d[g-1];
            nd[2*g]   = lvl(d[g-1][2*g-2], m_i(qam[g-1]), g);
            nd[2*g+1] = lvl(d[g-1][2*g-1], m_q(qam[g-1]), g);
         end
      end
      always_ff @(posedge clk)
         if (!rst_n) begin
            vld[g] <= 1'b0;
            sop[g] <= 1'b0;
            qam[g] <= '0;
            scl[g] <= '0;
            d[g]   <= '0;
         end else if (adv[g]) begin
            vld[g] <= pv;
            if (pv) begin
               sop[g] <= ps;
               qam[g] <= pq;
               scl[g] <= pc;
               d[g]   <= nd;
            end
         end
   end

   // B=1 falls out of ceil/floor naturally: mI=1, mQ=0
   always_comb begin
      lg = qam[N-2] != 5'd0 && int'(qam[N-2]) <= pBMAX;
      nl = '0;
      sd = '0;
      for (int j = 0; j < pBMAX; j++) begin
         sd = $signed(d[N-2][j]) >>> (pOUT_SHIFT + int'(scl[N-2]));
         sd = sd > MAXL ? MAXL : sd < -MAXL ? -MAXL : sd;
         nl[j*pLLR_W +: pLLR_W] = (lg && j / 2 < (j % 2 == 1 ? m_q(qam[N-2]) : m_i(qam[N-2])))
                                  ? sd[pLLR_W-1:0] : '0;
      end
   end

   always_ff @(posedge clk)
      if (!rst_n) begin
         ov   <= 1'b0;
         osop <= 1'b0;
         oq   <= '0;
         oe   <= 1'b0;
         ol   <= '0;
      end else if (adv[N-1]) begin
         ov <= vld[N-2];
         if (vld[N-2]) begin
            osop <= sop[N-2];
            oq   <= qam[N-2];
            oe   <= ~lg;
            ol   <= nl;
         end
      end

   assign bus.sym_rdy = adv[0];
   assign bus.llr_val = ov;
   assign bus.llr_sop = osop;
   assign bus.llr_qam = oq;
   assign bus.err     = oe;
   assign bus.llr     = ol;
endmodule

// File: tb/tb_llr_rect_qam_demapper.sv
// tb_llr_rect_qam_demapper: directed + randomized checks of the LLR demapper against an arithmetic model.
module tb_llr_rect_qam_demapper;
   localparam int BMAX = 12, DW = 9, LW = 4, PS = 4, OS = 4;
   localparam int S = (BMAX + 1) / 2 - 1, L = S + 2, W = DW + 1, MX = (1 << (LW - 1)) - 1;
   typedef struct packed {
      logic              sop;
      logic [4:0]        qam;
      logic              err;
      logic [BMAX*LW-1:0] llr;
   } exp_t;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   llr_rect_qam_demapper_if bus ();
   llr_rect_qam_demapper dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks = 0, errors = 0;
   exp_t q[$];
   exp_t snap, e2;
   int lat, acc, sc;
   logic have;

   function automatic int wrap(input int x);
      int y;
      y = x & ((1 << W) - 1);
      return y >= (1 << (W - 1)) ? y - (1 << W) : y;
   endfunction

   function automatic exp_t model(input logic s, input logic [4:0] b, input int re, input int im, input int scl);
      exp_t e;
      int mi, mq, m, d, v;
      e.sop = s;
      e.qam = b;
      e.err = (b == 0) || (int'(b) > BMAX);
      e.llr = '0;
      if (!e.err) begin
         mi = (b == 1) ? 1 : (int'(b) + 1) / 2;
         mq = (b == 1) ? 0 : int'(b) / 2;
         for (int ax = 0; ax < 2; ax++) begin
            m = ax == 1 ? mq : mi;
            d = ax == 1 ? im : re;
            for (int k = 0; k < m; k++) begin
               if (k > 0) d = wrap((1 << (m - k + PS)) - (d < 0 ? -d : d));
               v = d >>> (OS + scl);
               v = v > MX ? MX : (v < -MX ? -MX : v);
               e.llr[(2*k+ax)*LW +: LW] = v[LW-1:0];
            end
         end
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s got %h want %h", tag, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic s, input logic [4:0] b, input logic signed [DW-1:0] r, input logic signed [DW-1:0] i);
      bus.sym_sop = s;
      bus.sym_qam = b;
      bus.re = r;
      bus.im = i;
   endtask

   // drive one symbol starting at posedge+1; returns at posedge+1 after it is accepted
   task automatic send(input logic s, input logic [4:0] b, input logic signed [DW-1:0] r, input logic signed [DW-1:0] i);
      int n;
      put(s, b, r, i);
      bus.sym_val = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.sym_rdy && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("accept_timeout", 64'(n < 50), 1);
      step();
   endtask

   task automatic wait_out(output int l);
      l = 1;
      @(negedge clk);
      while (!bus.llr_val && l < 100) begin
         l++;
         @(negedge clk);
      end
      chk("out_timeout", 64'(l < 100), 1);
   endtask

   task automatic drain();
      int n;
      bus.sym_val = 1'b0;
      bus.llr_rdy = 1'b1;
      n = 0;
      while ((q.size() != 0 || bus.llr_val) && n < 200) begin
         n++;
         step();
      end
      @(negedge clk);
      chk("drain", 64'(q.size()), 0);
      step();
   endtask

   always @(negedge clk) begin
      if (!rst_n) q.delete();
      else begin
         if (bus.llr_val && bus.llr_rdy) begin
            chk("sb_unexpected_out", 64'(q.size() != 0), 1);
            if (q.size() != 0) begin
               e2 = q.pop_front();
               chk("sb_out", 64'({bus.llr_sop, bus.llr_qam, bus.err, bus.llr}), 64'(e2));
            end
         end
`ifdef LLR_DEMAP_ISCALE_EN
         sc = int'(bus.scale);
`else
         sc = 0;
`endif
         if (bus.sym_val && bus.sym_rdy)
            q.push_back(model(bus.sym_sop, bus.sym_qam, int'(bus.re), int'(bus.im), sc));
      end
   end

   initial begin
      bus.sym_val = 1'b0;
      bus.llr_rdy = 1'b1;
      put(0, 0, 0, 0);
`ifdef LLR_DEMAP_ISCALE_EN
      bus.scale = 2'd0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_oval", 64'(bus.llr_val), 0);
      chk("rst_iready", 64'(bus.sym_rdy), 1);
      chk("rst_osop", 64'(bus.llr_sop), 0);
      chk("rst_oerr", 64'(bus.err), 0);
      chk("rst_oqam", 64'(bus.llr_qam), 0);
      chk("rst_llr", 64'(bus.llr), 0);
      step();
      rst_n = 1'b1;
      step();

      send(1, 1, 40, 0);
      bus.sym_val = 1'b0;
      wait_out(lat);
      chk("bpsk_latency", 64'(lat), 64'(L));
      chk("bpsk_40", 64'(bus.llr), 64'h2);
      chk("bpsk_qam", 64'(bus.llr_qam), 1);
      step();

      send(0, 1, 255, 0);
      bus.sym_val = 1'b0;
      wait_out(lat);
      chk("bpsk_pos_sat", 64'(bus.llr), 64'h7);
      step();

      send(0, 1, -256, 0);
      bus.sym_val = 1'b0;
      wait_out(lat);
      chk("bpsk_neg_sat", 64'(bus.llr), 64'h9);
      step();

      send(0, 5, 40, -20);
      bus.sym_val = 1'b0;
      wait_out(lat);
      chk("qam32_llr", 64'(bus.llr), 64'h01E2);
      chk("qam32_qam", 64'(bus.llr_qam), 5);
      chk("qam32_err", 64'(bus.err), 0);
      step();

      send(1, 1,  DW'($urandom), DW'($urandom));
      send(0, 5,  DW'($urandom), DW'($urandom));
      send(0, 12, DW'($urandom), DW'($urandom));
      send(0, 0,  DW'($urandom), DW'($urandom));
      send(0, 3,  DW'($urandom), DW'($urandom));
      bus.sym_val = 1'b0;
      wait_out(lat);
      for (int i = 0; i < 5; i++) begin
         chk("mix_back_to_back", 64'(bus.llr_val), 1);
         chk("mix_sop", 64'(bus.llr_sop), 64'(i == 0));
         if (i == 3) begin
            chk("mix_b0_err", 64'(bus.err), 1);
            chk("mix_b0_llr", 64'(bus.llr), 0);
         end
         @(negedge clk);
      end
      step();
      drain();

      bus.llr_rdy = 1'b0;
      acc = 0;
      have = 1'b0;
      for (int c = 0; c < 20; c++) begin
         put(c == 0, 5'($urandom_range(0, 13)), DW'($urandom), DW'($urandom));
         bus.sym_val = 1'b1;
         @(negedge clk);
         if (bus.sym_rdy) acc++;
         if (bus.llr_val) begin
            if (have) chk("stall_hold", 64'({bus.llr_sop, bus.llr_qam, bus.err, bus.llr}), 64'(snap));
            else begin
               snap = {bus.llr_sop, bus.llr_qam, bus.err, bus.llr};
               have = 1'b1;
            end
         end
         step();
      end
      bus.sym_val = 1'b0;
      @(negedge clk);
      chk("bp_accepts", 64'(acc), 64'(L));
      chk("bp_iready_low", 64'(bus.sym_rdy), 0);
      chk("bp_oval_held", 64'(bus.llr_val), 1);
      step();
      drain();

      for (int c = 0; c < 300; c++) begin
         put($urandom_range(0, 1), 5'($urandom_range(0, 14)), DW'($urandom), DW'($urandom));
`ifdef LLR_DEMAP_ISCALE_EN
         bus.scale = 2'($urandom);
`endif
         bus.sym_val = ($urandom_range(0, 3) != 0);
         bus.llr_rdy = ($urandom_range(0, 3) != 0);
         step();
      end
`ifdef LLR_DEMAP_ISCALE_EN
      bus.scale = 2'd0;
`endif
      drain();

      for (int i = 0; i < 4; i++) send(i == 0, 5'($urandom_range(1, 12)), DW'($urandom), DW'($urandom));
      bus.sym_val = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_oval", 64'(bus.llr_val), 0);
      chk("rst_mid_iready", 64'(bus.sym_rdy), 1);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("rst_flushed", 64'(bus.llr_val), 0);
      end
      step();

`ifdef LLR_DEMAP_ISCALE_EN
      bus.scale = 2'd1;
      send(0, 1, 40, 0);
      bus.sym_val = 1'b0;
      wait_out(lat);
      chk("iscale1", 64'(bus.llr), 64'h1);
      step();
      bus.scale = 2'd3;
      send(0, 1, 40, 0);
      bus.sym_val = 1'b0;
      wait_out(lat);
      chk("iscale3", 64'(bus.llr), 64'h0);
      step();
      bus.scale = 2'd0;
`endif

      drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
